// File: rtl/seq_addsub_nb.sv
// Purpose: serial adder/subtractor, STEP bits per cycle through a ripple slice.
// Latency: done pulses WIDTH/STEP edges after the edge that samples start.
// Backpressure: none; start is only taken in IDLE and ignored while busy.
module seq_addsub_nb #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_slice;
  logic [STEP-1:0]  slice_sum;
  logic             slice_cout;
  logic             carry_msb;
  logic             chain;

  assign last_slice = (cnt == CW'(N - 1));

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs; DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One STEP-bit ripple slice on the low bits of the shifting operands;
  // carry_msb ends as the carry into the slice's top bit, used for overflow.
  always_comb begin
    chain     = carry;
    carry_msb = carry;
    slice_sum = '0;
    for (int i = 0; i < STEP; i++) begin
      carry_msb    = chain;
      slice_sum[i] = op_a[i] ^ op_b[i] ^ chain;
      chain        = (op_a[i] & op_b[i]) | (chain & (op_a[i] ^ op_b[i]));
    end
    slice_cout = chain;
  end

  // Result accumulates from the top down so the LSB slice lands at bit 0.
  always_comb begin
    acc_nxt                    = acc >> STEP;
    acc_nxt[WIDTH-1 -: STEP]   = slice_sum;
  end

  // Operand capture, slice iteration and result commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c     <= 1'b0;
      v     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          op_a  <= op_a >> STEP;
          op_b  <= op_b >> STEP;
          carry <= slice_cout;
          cnt   <= cnt + CW'(1);
          acc   <= acc_nxt;
          if (last_slice) begin
            s <= acc_nxt;
            c <= slice_cout;
            v <= carry_msb ^ slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub_nb.sv
module tb_seq_addsub_nb;

  localparam int W = 8;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c, v;
  logic [W-1:0] s;

  logic         t4_start = 1'b0;
  logic [7:0]   t4_a = '0, t4_b = '0, t4_s;
  logic         t4_busy, t4_done, t4_c, t4_v;

  logic         t16_start = 1'b0;
  logic [15:0]  t16_a = '0, t16_b = '0, t16_s;
  logic         t16_busy, t16_done, t16_c, t16_v;

  int checks = 0;
  int failures = 0;

  seq_addsub_nb #(.WIDTH(8), .STEP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .c(c), .v(v)
  );

  seq_addsub_nb #(.WIDTH(8), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(t4_start), .sub(1'b0), .a(t4_a), .b(t4_b),
    .busy(t4_busy), .done(t4_done), .s(t4_s), .c(t4_c), .v(t4_v)
  );

  seq_addsub_nb #(.WIDTH(16), .STEP(2)) dut16 (
    .clk(clk), .rst(rst), .start(t16_start), .sub(1'b0), .a(t16_a), .b(t16_b),
    .busy(t16_busy), .done(t16_done), .s(t16_s), .c(t16_c), .v(t16_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic plus the sign rule for overflow.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic is_sub);
    logic [W:0]   sum;
    logic [W-1:0] r;
    logic         ov;
    if (is_sub) sum = {1'b0, x} - {1'b0, y} + (W+1)'(1 << W);
    else        sum = {1'b0, x} + {1'b0, y};
    r = sum[W-1:0];
    if (is_sub) ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else        ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {ov, sum[W], r};
  endfunction

  // Timing model: cycles since acceptance; 0 idle, 1..N running, N+1 done.
  int           m_cnt = 0;
  logic [W-1:0] m_s = '0, p_s = '0;
  logic         m_c = 1'b0, m_v = 1'b0, p_c = 1'b0, p_v = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      m_s = '0;
      m_c = 1'b0;
      m_v = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        {p_v, p_c, p_s} = ref_op(a, b, sub);
        m_cnt = 1;
      end
    end else if (m_cnt < N) begin
      m_cnt++;
    end else if (m_cnt == N) begin
      m_cnt = N + 1;
      m_s = p_s;
      m_c = p_c;
      m_v = p_v;
    end else begin
      m_cnt = 0;
    end
  end

  // Every-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("done", 32'(done), 32'(m_cnt == N + 1));
    chk("s", 32'(s), 32'(m_s));
    chk("c", 32'(c), 32'(m_c));
    chk("v", 32'(v), 32'(m_v));
  end

  // Launch one op from IDLE; operands are scrambled after sampling.
  // lat = edges from sampling to done, bc = cycles busy was high.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic is_sub,
                        output int lat, output int bc);
    @(negedge clk);
    a = x; b = y; sub = is_sub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    bc = busy ? 1 : 0;
    for (int e = 1; e < 40 && busy; e++) begin
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      @(posedge clk);
      #1;
      if (busy) bc++;
      if (done && lat == 0) lat = e;
    end
  endtask

  task automatic run_lit(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic is_sub, input logic [W-1:0] es, input logic ec,
                         input logic ev);
    int lat, bc;
    run_op(x, y, is_sub, lat, bc);
    chk({name, "_lat"}, 32'(lat), 32'(N));
    chk({name, "_busy_cycles"}, 32'(bc), 32'(N + 1));
    chk({name, "_s"}, 32'(s), 32'(es));
    chk({name, "_c"}, 32'(c), 32'(ec));
    chk({name, "_v"}, 32'(v), 32'(ev));
  endtask

  initial begin
    int lat, bc, dn;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cv", 32'({c, v}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_lit("p7f_p01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_lit("pff_p01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_lit("p00_m01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_lit("p80_m01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Reset during the third RUN cycle, then hold reset with start high.
    @(negedge clk);
    a = 8'h55; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_s", 32'(s), 32'd0);
    chk("mid_rst_cv", 32'({c, v}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    run_lit("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    // Idle with wiggling inputs: outputs must hold.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    end
    chk("idle_s", 32'(s), 32'h07);
    chk("idle_busy", 32'(busy), 32'd0);

    // start held high with operands changing every cycle.
    @(negedge clk);
    start = 1'b1;
    dn = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    end
    start = 1'b0;
    chk("held_start_ops", 32'(dn), 32'd10);
    repeat (12) @(posedge clk);

    // Random operations checked by the per-cycle model.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), lat, bc);
      chk("rand_lat", 32'(lat), 32'(N));
    end

    // STEP=4 instance.
    @(negedge clk);
    t4_a = 8'hA5; t4_b = 8'h5B; t4_start = 1'b1;
    @(posedge clk);
    #1 t4_start = 1'b0;
    t4_a = 8'h00; t4_b = 8'h00;
    lat = 0;
    for (int e = 1; e < 20 && lat == 0; e++) begin
      @(posedge clk);
      #1;
      if (t4_done) lat = e;
    end
    chk("w8s4_lat", 32'(lat), 32'd2);
    chk("w8s4_s", 32'(t4_s), 32'h00);
    chk("w8s4_cv", 32'({t4_c, t4_v}), 32'b10);

    // WIDTH=16 STEP=2 instance.
    @(negedge clk);
    t16_a = 16'h1234; t16_b = 16'h0FFF; t16_start = 1'b1;
    @(posedge clk);
    #1 t16_start = 1'b0;
    t16_a = 16'hFFFF; t16_b = 16'hFFFF;
    lat = 0;
    for (int e = 1; e < 30 && lat == 0; e++) begin
      @(posedge clk);
      #1;
      if (t16_done) lat = e;
    end
    chk("w16s2_lat", 32'(lat), 32'd8);
    chk("w16s2_s", 32'(t16_s), 32'h2233);
    chk("w16s2_cv", 32'({t16_c, t16_v}), 32'b00);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
